// File: rtl/alu_mb_seq.sv
// alu_mb_seq: multi-byte ADD/SUB/AND/OR sequencer driving one external
// combinational 8-bit ALU slice, one byte per cycle, LSB first, with the
// carry chained between bytes.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   start_in, op_in         request / opcode (00 ADD, 01 SUB, 10 AND, 11 OR)
//   a_in, b_in              W-bit operands, sampled only when a start is accepted
//   busy_out, done_out      operation in progress / one-cycle completion pulse
//   result_out, carry_out   W-bit result and carry (SUB: 1 = no borrow)
//   alu_*_out               drives to the ALU slice (from registered state only)
//   alu_result_in/cout_in   ALU slice outputs
//
// state | meaning
// IDLE  | waiting for start_in
// RUN   | one byte per cycle through the ALU slice, idx_q selects the byte
// DONE  | one-cycle done pulse; a new start is accepted here
module alu_mb_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [1:0]            op_in,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [8*NBYTES-1:0]   result_out,
  output logic                  carry_out,
  output logic [7:0]            alu_a_out,
  output logic [7:0]            alu_b_out,
  output logic                  alu_cin_out,
  output logic [2:0]            alu_opcode_out,
  input  logic [7:0]            alu_result_in,
  input  logic                  alu_cout_in
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_AND = 2'd2, OP_OR = 2'd3} op_t;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_int_q, res_int_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_out_q, carry_out_d;

  logic [7:0]     a_byte;
  logic [7:0]     b_byte;
  logic           arith;

  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    a_byte = 8'h00;
    b_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
  end

  // Slice drives depend only on registered state, so there is no
  // combinational loop through the external ALU.
  always_comb begin
    alu_a_out      = 8'h00;
    alu_b_out      = 8'h00;
    alu_cin_out    = 1'b0;
    alu_opcode_out = 3'b111;
    if (state_q == RUN) begin
      alu_a_out = a_byte;
      unique case (op_q)
        OP_ADD: begin
          alu_b_out      = b_byte;
          alu_cin_out    = carry_q;
          alu_opcode_out = 3'b000;
        end
        OP_SUB: begin
          // Subtract as A + ~B + 1 on the add path; the slice's own subtract
          // opcode does not report a borrow.
          alu_b_out      = ~b_byte;
          alu_cin_out    = carry_q;
          alu_opcode_out = 3'b000;
        end
        OP_AND: begin
          alu_b_out      = b_byte;
          alu_opcode_out = 3'b010;
        end
        default: begin
          alu_b_out      = b_byte;
          alu_opcode_out = 3'b011;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    res_int_d   = res_int_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op_t'(op_in);
          idx_d   = '0;
          carry_d = (op_t'(op_in) == OP_SUB);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) res_int_d[8*i +: 8] = alu_result_in;
        end
        carry_d = arith ? alu_cout_in : 1'b0;
        if (idx_q == IW'(NBYTES - 1)) begin
          // Final byte: publish the assembled word and the MSB carry; the
          // carry is not fed back into byte 0.
          result_d    = res_int_d;
          carry_out_d = carry_d;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_int_q   <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_int_q   <= res_int_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign busy_out   = (state_q == RUN);
  assign done_out   = (state_q == DONE);
  assign result_out = result_q;
  assign carry_out  = carry_out_q;

endmodule

// File: tb/tb_alu_mb_seq.sv
module tb_alu_mb_seq;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start_in = 1'b0;
  logic [1:0]     op_in = 2'b00;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           busy_out, done_out, carry_out;
  logic [W-1:0]   result_out;
  logic [7:0]     alu_a_out, alu_b_out, alu_result_in;
  logic           alu_cin_out, alu_cout_in;
  logic [2:0]     alu_opcode_out;

  alu_mb_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .busy_out(busy_out), .done_out(done_out),
    .result_out(result_out), .carry_out(carry_out),
    .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_cin_out(alu_cin_out),
    .alu_opcode_out(alu_opcode_out), .alu_result_in(alu_result_in),
    .alu_cout_in(alu_cout_in)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit ALU slice.
  logic [8:0] slice_sum;
  always_comb begin
    slice_sum     = 9'd0;
    alu_result_in = 8'h00;
    alu_cout_in   = 1'b0;
    case (alu_opcode_out)
      3'b000: begin
        slice_sum     = {1'b0, alu_a_out} + {1'b0, alu_b_out} + {8'd0, alu_cin_out};
        alu_result_in = slice_sum[7:0];
        alu_cout_in   = slice_sum[8];
      end
      3'b001:  alu_result_in = alu_a_out - alu_b_out;
      3'b010:  alu_result_in = alu_a_out & alu_b_out;
      3'b011:  alu_result_in = alu_a_out | alu_b_out;
      default: alu_result_in = 8'h00;
    endcase
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;
  logic       cin_log [0:15];
  logic [7:0] b_log   [0:15];
  logic [2:0] opc_log [0:15];

  always @(negedge clk) if (done_out) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    s = '0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; e.r = s[W-1:0]; e.c = s[W]; end
      2'b01: begin e.r = a - b; e.c = (a >= b); end
      2'b10: begin e.r = a & b; e.c = 1'b0; end
      default: begin e.r = a | b; e.c = 1'b0; end
    endcase
    return e;
  endfunction

  // Called #1 after a posedge or at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    if (push) q.push_back(model(op, a, b));
    op_in = op; a_in = a; b_in = b; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  // Counts cycles (negedge samples) until done_out, logging slice drives.
  task automatic wait_done(input string tag, output int lat);
    exp_t e;
    lat = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      lat = i;
      cin_log[i] = alu_cin_out;
      b_log[i]   = alu_b_out;
      opc_log[i] = alu_opcode_out;
      if (done_out) break;
    end
    if (!done_out) begin
      check({tag, "_timeout"}, 64'(done_out), 64'd1);
      if (q.size() > 0) void'(q.pop_front());
    end else if (q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(q.size()), 64'd1);
    end else begin
      e = q.pop_front();
      check({tag, "_result"}, 64'(result_out), 64'(e.r));
      check({tag, "_carry"},  64'(carry_out),  64'(e.c));
      check({tag, "_busy_in_done"}, 64'(busy_out), 64'd0);
    end
  endtask

  initial begin
    int lat;
    int dc0;

    // Reset state
    #12;
    check("rst_busy",   64'(busy_out),   64'd0);
    check("rst_done",   64'(done_out),   64'd0);
    check("rst_result", 64'(result_out), 64'd0);
    check("rst_carry",  64'(carry_out),  64'd0);
    check("rst_opcode", 64'(alu_opcode_out), 64'd7);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: ADD with carry into byte 1
    issue(2'b00, 32'h000000FF, 32'h00000001, 1'b1);
    check("t1_busy", 64'(busy_out), 64'd1);
    wait_done("t1", lat);
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_cin", 64'({cin_log[1], cin_log[2], cin_log[3], cin_log[4]}), 64'b0100);

    // 2: ADD wraps out of MSB; SUB with no borrow
    @(negedge clk);
    issue(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    wait_done("t2_add", lat);
    @(negedge clk);
    issue(2'b01, 32'h00000100, 32'h00000001, 1'b1);
    wait_done("t2_sub", lat);
    check("t2_sub_cin0", 64'(cin_log[1]), 64'd1);

    // 3: SUB with borrow
    @(negedge clk);
    issue(2'b01, 32'h00000000, 32'h00000001, 1'b1);
    wait_done("t3", lat);
    check("t3_b_byte0", 64'(b_log[1]), 64'hFE);
    check("t3_opcodes", 64'({opc_log[1], opc_log[2], opc_log[3], opc_log[4]}), 64'd0);
    @(negedge clk);
    check("t3_idle_opcode", 64'(alu_opcode_out), 64'd7);

    // 4: AND then OR issued back-to-back in the DONE cycle
    issue(2'b10, 32'hF0F0A5A5, 32'hFF00FFFF, 1'b1);
    wait_done("t4_and", lat);
    check("t4_and_opcode", 64'(opc_log[1]), 64'd2);
    issue(2'b11, 32'hF0F0A5A5, 32'hFF00FFFF, 1'b1);
    wait_done("t4_or", lat);
    check("t4_or_latency", 64'(lat), 64'd5);
    check("t4_or_opcode", 64'(opc_log[2]), 64'd3);

    // 5: start pulse and operand change during RUN are ignored
    @(negedge clk);
    dc0 = done_cnt;
    issue(2'b00, 32'h01020304, 32'h10203040, 1'b1);
    @(negedge clk);
    start_in = 1'b1; op_in = 2'b11; a_in = 32'hDEADBEEF; b_in = 32'h55555555;
    @(negedge clk);
    start_in = 1'b0; a_in = 32'h0BADF00D;
    wait_done("t5", lat);
    check("t5_latency", 64'(lat + 2), 64'd5);
    repeat (8) @(negedge clk);
    check("t5_one_done", 64'(done_cnt - dc0), 64'd1);

    // 6: async reset in RUN byte 2
    dc0 = done_cnt;
    issue(2'b00, 32'hAAAAAAAA, 32'h11111111, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy",   64'(busy_out),   64'd0);
    check("t6_done",   64'(done_out),   64'd0);
    check("t6_result", 64'(result_out), 64'd0);
    check("t6_carry",  64'(carry_out),  64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_done", 64'(done_cnt - dc0), 64'd0);
    issue(2'b00, 32'h12345678, 32'h11111111, 1'b1);
    wait_done("t6_after", lat);
    check("t6_after_latency", 64'(lat), 64'd5);

    // A few random operations
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'b1);
      wait_done("rand", lat);
    end

    check("sb_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mb_seq.md
Name: alu_mb_seq

Overview:
- Multi-byte arithmetic/logic sequencer that drives one external 8-bit ALU slice (3-bit opcode, A/B/Cin in, Result/Cout out).
- Executes NBYTES-wide ADD/SUB/AND/OR one byte per cycle, LSB first, chaining carry between bytes.
- Sits between the control/register block and the ALU slice.
- Single-operation-in-flight start/busy/done handshake.

Parameters:
NBYTES, 4, operand width in bytes (>=1); operand width W = 8*NBYTES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_in  in  1  request new operation; sampled only when not busy
op_in  in  2  00 ADD, 01 SUB, 10 AND, 11 OR
a_in  in  W  operand A
b_in  in  W  operand B
busy_out  out  1  operation in progress
done_out  out  1  one-cycle pulse, result_out/carry_out valid
result_out  out  W  result, held until next accepted start
carry_out  out  1  ADD: carry out of MSB; SUB: 1 = no borrow (A>=B unsigned); AND/OR: 0
alu_a_out  out  8  ALU A_in drive
alu_b_out  out  8  ALU B_in drive
alu_cin_out  out  1  ALU C_in drive
alu_opcode_out  out  3  ALU Opcode_in drive
alu_result_in  in  8  ALU Result_out
alu_cout_in  in  1  ALU C_out

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values (async, immediate):
  - FSM=IDLE; busy_out=0; done_out=0; result_out=0; carry_out=0.
  - Internal byte index, carry, latched operands and op all 0.
- ALU slice is purely combinational. All ALU drive outputs are combinational from registered state only, so there is no loop through the slice.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start_in=1:
  - Latch a_in, b_in, op_in.
  - idx <= 0; carry <= 1 if SUB else 0.
  - Go to RUN; busy_out=1 from next cycle.
- IDLE/DONE, start_in=0: go to (or stay in) IDLE.
- RUN, each cycle with k = idx:
  - alu_a_out = A[8k+7:8k].
  - ADD: alu_b_out = B byte; alu_opcode_out=000; alu_cin_out=carry.
  - SUB: alu_b_out = ~B byte; alu_opcode_out=000; alu_cin_out=carry. This is two's-complement via the add path, because the slice's own subtract opcode gives no borrow.
  - AND: alu_opcode_out=010; alu_cin_out=0.
  - OR: alu_opcode_out=011; alu_cin_out=0.
  - Register alu_result_in into an internal result byte k.
  - carry <= alu_cout_in for ADD/SUB, else 0.
  - If k == NBYTES-1: go to DONE; else idx <= k+1.
- DONE (one cycle):
  - done_out=1, busy_out=0.
  - result_out and carry_out updated from internal registers on entry to DONE and held through IDLE.
  - A start in DONE is accepted (back-to-back).
- Drives outside RUN: alu_a_out=0, alu_b_out=0, alu_cin_out=0, alu_opcode_out=111 (slice returns 0).
- Latency: start accepted at edge 0 -> done_out high in cycle NBYTES+1. Throughput: one op per NBYTES+1 cycles.
- start_in while busy_out=1 is ignored; no queuing, no error flag.
- op_in, a_in, b_in are only sampled at acceptance; later changes have no effect.
- NBYTES=1: one RUN cycle, then DONE.
- Reset mid-RUN: abort immediately. No done pulse. result_out=0 after reset.
- Carry wrap: the MSB carry does not wrap into bit 0; the result is modulo 2^W.

Test Plan:
1. NBYTES=4, ADD A=0x000000FF, B=0x00000001 -> done at cycle 5; result 0x00000100, carry_out 0; alu_cin_out 0/1/0/0 over the 4 RUN cycles.
2. ADD A=0xFFFFFFFF, B=0x00000001 -> result 0x00000000, carry_out 1. SUB A=0x00000100, B=0x00000001 -> result 0x000000FF, carry_out 1.
3. SUB A=0x00000000, B=0x00000001 -> result 0xFFFFFFFF, carry_out 0. Check alu_b_out=0xFE on byte 0 and alu_opcode_out=000 throughout.
4. AND A=0xF0F0A5A5, B=0xFF00FFFF -> 0xF000A5A5, carry 0. OR same operands -> 0xFFF0FFFF, carry 0. Issue OR back-to-back in the DONE cycle; its done arrives 5 cycles later.
5. Start ADD, then pulse start_in with different operands during RUN, then change a_in mid-RUN -> both ignored; the original result is returned and exactly one done pulse occurs.
6. Assert rst_n=0 asynchronously in RUN byte 2 -> busy/done/result/carry go to 0 immediately with no done pulse. After release, a new ADD 0x12345678+0x11111111 -> 0x23456789.
